// File: rtl/pair_triple_stim_gen_if.sv
// Handshake and vector bundle between pair_triple_stim_gen and its consumer/detector.
// det_in/err_count exist only when PAIR_TRIPLE_STIM_GEN_SELFCHECK_EN is defined.
interface pair_triple_stim_gen_if;
  logic       req_val;
  logic       req_rdy;
  logic [1:0] req_count;
  logic       req_all;
  logic       out0;
  logic       out1;
  logic       out2;
  logic       out_val;
  logic       out_rdy;
  logic       out_last;
  logic       busy;
`ifdef PAIR_TRIPLE_STIM_GEN_SELFCHECK_EN
  logic       det_in;
  logic [3:0] err_count;

  modport master (
    input  req_val, req_count, req_all, out_rdy, det_in,
    output req_rdy, out0, out1, out2, out_val, out_last, busy, err_count
  );

  modport slave (
    output req_val, req_count, req_all, out_rdy, det_in,
    input  req_rdy, out0, out1, out2, out_val, out_last, busy, err_count
  );
`else
  modport master (
    input  req_val, req_count, req_all, out_rdy,
    output req_rdy, out0, out1, out2, out_val, out_last, busy
  );

  modport slave (
    output req_val, req_count, req_all, out_rdy,
    input  req_rdy, out0, out1, out2, out_val, out_last, busy
  );
`endif
endinterface

// File: rtl/pair_triple_stim_gen.sv
// Enumerates 3-bit vectors by popcount (or all eight) for the majority-of-three detector.
// Optional detector self-check is built when PAIR_TRIPLE_STIM_GEN_SELFCHECK_EN is defined.
module pair_triple_stim_gen (
  input logic                    clk,
  input logic                    rst,
  pair_triple_stim_gen_if.master bus
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t     r_state, w_stateNext;
  logic [2:0] r_vec, w_vecNext;
  logic [1:0] r_count, w_countNext;
  logic       r_all, w_allNext;

  logic [2:0] w_firstVec;
  logic [2:0] w_succVec;
  logic       w_hasSucc;
  logic       w_reqRdy;
  logic       w_outVal;
  logic       w_accept;
  logic       w_xfer;

  function automatic logic f_match(input logic [2:0] v, input logic [1:0] cnt, input logic all);
    logic [1:0] ones;
    ones = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    return all || (ones == cnt);
  endfunction

  assign w_reqRdy = (r_state == S_IDLE);
  assign w_outVal = (r_state == S_EMIT);
  assign w_accept = bus.req_val && w_reqRdy;
  assign w_xfer   = w_outVal && bus.out_rdy;

  // Lowest matching vector for the incoming request; every filter has at least one match.
  always_comb begin
    w_firstVec = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (f_match(3'(i), bus.req_count, bus.req_all)) begin
        w_firstVec = 3'(i);
      end
    end
  end

  always_comb begin
    w_succVec = r_vec;
    w_hasSucc = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if ((i > int'(r_vec)) && f_match(3'(i), r_count, r_all)) begin
        w_succVec = 3'(i);
        w_hasSucc = 1'b1;
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_vecNext   = r_vec;
    w_countNext = r_count;
    w_allNext   = r_all;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_countNext = bus.req_count;
          w_allNext   = bus.req_all;
          w_vecNext   = w_firstVec;
          w_stateNext = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_xfer) begin
          if (w_hasSucc) begin
            w_vecNext = w_succVec;
          end else begin
            w_stateNext = S_IDLE;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vec   <= 3'd0;
      r_count <= 2'd0;
      r_all   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_vec   <= w_vecNext;
      r_count <= w_countNext;
      r_all   <= w_allNext;
    end
  end

  assign bus.req_rdy  = w_reqRdy;
  assign bus.out_val  = w_outVal;
  assign bus.busy     = w_outVal;
  assign bus.out_last = w_outVal && !w_hasSucc;
  assign bus.out0     = r_vec[0];
  assign bus.out1     = r_vec[1];
  assign bus.out2     = r_vec[2];

`ifdef PAIR_TRIPLE_STIM_GEN_SELFCHECK_EN
  logic [3:0] r_errCount;
  logic       w_expected;

  assign w_expected = (r_vec[0] & r_vec[1]) | (r_vec[2] & (r_vec[0] | r_vec[1]));

  // Survives new requests; only reset clears the tally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_errCount <= 4'd0;
    end else if (w_xfer && (bus.det_in != w_expected) && (r_errCount != 4'd15)) begin
      r_errCount <= r_errCount + 4'd1;
    end
  end

  assign bus.err_count = r_errCount;
`endif

endmodule
